stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/mod_cnt_en.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit geometry for the stopwatch controller.
// Digit order is tenths, seconds-ones, seconds-tens (display 59.9 max).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam int TENTHS_W   = 4;
  localparam int ONES_W     = 4;
  localparam int TENS_W     = 3;

  localparam int TENTHS_MOD = 10;
  localparam int ONES_MOD   = 10;
  localparam int TENS_MOD   = 6;

endpackage

// File: rtl/mod_cnt_en.sv
// Modulo-MOD digit counter with enable and synchronous clear.
// carry is combinational so a chain of these settles within one cycle.
module mod_cnt_en #(
  parameter int MOD  = 10,
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [BITS-1:0] count,
  output logic            carry
);

  logic [BITS-1:0] count_q, count_d;

  assign carry = en && (count_q == BITS'(MOD - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (carry)
      count_d = '0;
    else if (en)
      count_d = count_q + BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop + lap/reset stopwatch: button edge detect, 4-state FSM,
// inline tick prescaler, three cascaded digit counters and a lap snapshot.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int PDW      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_ss,
  input  logic                btn_lr,
  output logic [TENTHS_W-1:0] tenths,
  output logic [ONES_W-1:0]   sec_ones,
  output logic [TENS_W-1:0]   sec_tens,
  output logic                running,
  output logic                lap_frozen,
  output logic                wrap
);

  sw_state_e state_q, state_d;

  logic ss_q, lr_q, arm_q;
  logic ss_edge, lr_edge;

  logic           count_en, clr, snap_load, tick;
  logic [PDW-1:0] presc_q, presc_d;

  logic [TENTHS_W-1:0] live_tenths, snap_tenths_q;
  logic [ONES_W-1:0]   live_ones,   snap_ones_q;
  logic [TENS_W-1:0]   live_tens,   snap_tens_q;
  logic                tenths_carry, ones_carry, tens_carry;
  logic                wrap_q;

  // arm_q masks the first sample after reset so a held button is not an edge.
  assign ss_edge = arm_q && btn_ss && !ss_q;
  assign lr_edge = arm_q && btn_lr && !lr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ss_q    <= 1'b0;
      lr_q    <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= btn_ss;
      lr_q    <= btn_lr;
      arm_q   <= 1'b1;
    end
  end

  // ss always takes priority over a coincident lr edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_edge) state_d = RUN;
      RUN:     if (ss_edge) state_d = PAUSE; else if (lr_edge) state_d = LAP;
      LAP:     if (ss_edge) state_d = PAUSE; else if (lr_edge) state_d = RUN;
      PAUSE:   if (ss_edge) state_d = RUN;   else if (lr_edge) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_en   = (state_q == RUN) || (state_q == LAP);
    running    = count_en;
    lap_frozen = (state_q == LAP);
    clr        = (state_q == PAUSE) && lr_edge && !ss_edge;
    snap_load  = (state_q == RUN) && lr_edge && !ss_edge;
  end

  // Prescaler holds while paused so a resume loses no partial tick.
  assign tick = count_en && (presc_q == PDW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (clr || tick)
      presc_d = '0;
    else if (count_en)
      presc_d = presc_q + PDW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc_q <= '0;
    else
      presc_q <= presc_d;
  end

  mod_cnt_en #(.MOD(TENTHS_MOD), .BITS(TENTHS_W)) u_tenths (
    .clk   (clk),
    .rst   (rst),
    .en    (tick),
    .clr   (clr),
    .count (live_tenths),
    .carry (tenths_carry)
  );

  mod_cnt_en #(.MOD(ONES_MOD), .BITS(ONES_W)) u_ones (
    .clk   (clk),
    .rst   (rst),
    .en    (tenths_carry),
    .clr   (clr),
    .count (live_ones),
    .carry (ones_carry)
  );

  mod_cnt_en #(.MOD(TENS_MOD), .BITS(TENS_W)) u_tens (
    .clk   (clk),
    .rst   (rst),
    .en    (ones_carry),
    .clr   (clr),
    .count (live_tens),
    .carry (tens_carry)
  );

  // wrap_q lines up with the cycle the display first reads 00.0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_tenths_q <= '0;
      snap_ones_q   <= '0;
      snap_tens_q   <= '0;
      wrap_q        <= 1'b0;
    end else begin
      wrap_q <= tens_carry;
      if (snap_load) begin
        snap_tenths_q <= live_tenths;
        snap_ones_q   <= live_ones;
        snap_tens_q   <= live_tens;
      end
    end
  end

  assign wrap     = wrap_q;
  assign tenths   = lap_frozen ? snap_tenths_q : live_tenths;
  assign sec_ones = lap_frozen ? snap_ones_q   : live_ones;
  assign sec_tens = lap_frozen ? snap_tens_q   : live_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4: one tick every 4 running cycles.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic       running;
  logic       lap_frozen;
  logic       wrap;

  int n_vec;
  int n_err;

  stopwatch_ctrl #(.TICK_DIV(4), .PDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .tenths     (tenths),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .running    (running),
    .lap_frozen (lap_frozen),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display packed as 0xTOn (seconds-tens, seconds-ones, tenths) for readability.
  function automatic logic [31:0] disp();
    return {20'd0, 1'b0, sec_tens, sec_ones, tenths};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss();
    btn_ss = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
  endtask

  task automatic pulse_lr();
    btn_lr = 1'b1;
    @(negedge clk);
    btn_lr = 1'b0;
  endtask

  task automatic pulse_both();
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    int wcnt;
    int wat;
    logic [31:0] d_pre;
    logic [31:0] d_roll;

    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    #2 rst = 1'b0;
    cyc(2);

    // Reset state and basic run
    chk("rst_disp", disp(), 32'h000);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_lap", {31'd0, lap_frozen}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    rst = 1'b1;
    cyc(1);
    pulse_lr();
    chk("idle_lr_running", {31'd0, running}, 32'd0);
    chk("idle_lr_disp", disp(), 32'h000);
    pulse_ss();
    chk("start_running", {31'd0, running}, 32'd1);
    cyc(40);
    chk("run40_disp", disp(), 32'h010);
    chk("run40_running", {31'd0, running}, 32'd1);
    chk("run40_lap", {31'd0, lap_frozen}, 32'd0);

    // Wrap after 600 ticks
    apply_reset();
    pulse_ss();
    wcnt   = 0;
    wat    = 0;
    d_pre  = '0;
    d_roll = '0;
    for (int i = 1; i <= 2402; i++) begin
      cyc(1);
      if (wrap) begin
        wcnt++;
        wat = i;
      end
      if (i == 2399) d_pre = disp();
      if (i == 2400) d_roll = disp();
    end
    chk("wrap_pre_disp", d_pre, 32'h599);
    chk("wrap_roll_disp", d_roll, 32'h000);
    chk("wrap_pulse_count", wcnt, 32'd1);
    chk("wrap_pulse_cycle", wat, 32'd2400);

    // Lap freeze and release
    apply_reset();
    pulse_ss();
    cyc(92);
    chk("lap_pre_disp", disp(), 32'h023);
    pulse_lr();
    chk("lap_enter_disp", disp(), 32'h023);
    chk("lap_enter_frozen", {31'd0, lap_frozen}, 32'd1);
    chk("lap_enter_running", {31'd0, running}, 32'd1);
    cyc(20);
    chk("lap_hold_disp", disp(), 32'h023);
    pulse_lr();
    chk("lap_exit_disp", disp(), 32'h028);
    chk("lap_exit_frozen", {31'd0, lap_frozen}, 32'd0);
    chk("lap_exit_running", {31'd0, running}, 32'd1);

    // Pause keeps the prescaler phase; pause+lr clears everything
    apply_reset();
    pulse_ss();
    cyc(21);
    chk("pause_pre_disp", disp(), 32'h005);
    pulse_ss();
    chk("pause_running", {31'd0, running}, 32'd0);
    cyc(100);
    chk("pause_hold_disp", disp(), 32'h005);
    pulse_ss();
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_q0_disp", disp(), 32'h005);
    cyc(1);
    chk("resume_q1_disp", disp(), 32'h005);
    cyc(1);
    chk("resume_q2_disp", disp(), 32'h006);
    pulse_ss();
    pulse_lr();
    chk("clear_disp", disp(), 32'h000);
    chk("clear_running", {31'd0, running}, 32'd0);
    pulse_ss();
    cyc(3);
    chk("clear_presc_r3", disp(), 32'h000);
    cyc(1);
    chk("clear_presc_r4", disp(), 32'h001);

    // Simultaneous edges: ss wins
    apply_reset();
    pulse_ss();
    cyc(10);
    chk("both_pre_disp", disp(), 32'h002);
    pulse_both();
    chk("both_running", {31'd0, running}, 32'd0);
    chk("both_lap", {31'd0, lap_frozen}, 32'd0);
    cyc(8);
    chk("both_hold_disp", disp(), 32'h002);

    // Asynchronous reset mid-run, button held through deassertion
    apply_reset();
    pulse_ss();
    cyc(148);
    chk("rstmid_pre_disp", disp(), 32'h037);
    btn_ss = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rstmid_async_disp", disp(), 32'h000);
    chk("rstmid_async_running", {31'd0, running}, 32'd0);
    chk("rstmid_async_lap", {31'd0, lap_frozen}, 32'd0);
    chk("rstmid_async_wrap", {31'd0, wrap}, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(4);
    chk("held_btn_running", {31'd0, running}, 32'd0);
    chk("held_btn_disp", disp(), 32'h000);
    btn_ss = 1'b0;
    cyc(1);
    pulse_ss();
    chk("after_release_running", {31'd0, running}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
